mem_access: RTL and testbench
=============================

MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 clk  in  1  system clock, all state updates on rising edge.
REQ-002 rst  in  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-003 load  in  1  load request from EX_MEM.
REQ-004 save  in  1  save request from EX_MEM.
REQ-005 sl_reg_address  in  32  byte address of access.
REQ-006 sl_data  in  32  store data, little-endian, low bytes used.
REQ-007 sl_data_length  in  3  access size in bytes: 1, 2 or 4.
REQ-008 sl_data_signed  in  1  load sign-extend enable.
REQ-009 mem_din  in  8  RAM read byte, valid one cycle after its address is driven.
REQ-010 mem_a  out  32  RAM byte address, registered.
REQ-011 mem_dout  out  8  RAM write byte, registered.
REQ-012 mem_wr  out  1  RAM write strobe, registered; 1 = write mem_dout to mem_a this cycle.
REQ-013 stall_req  out  1  combinational pipeline hold request.
REQ-014 ld_valid  out  1  one-cycle pulse; ld_data holds the completed load.
REQ-015 ld_data  out  32  assembled, extended load result.
REQ-016 misalign  out  1  one-cycle misaligned-access pulse (present only with MEM_MISALIGN_TRAP_EN).

Function
REQ-017 States IDLE, RD, WR, DONE; IDLE accepts a request when load|save=1 in that cycle (cycle T), capturing address, data, length, signed.
REQ-018 Simultaneous load and save SHALL be treated as load; save ignored.
REQ-019 stall_req SHALL be 1 when state is RD or WR, or when state is IDLE with load|save=1; 0 in DONE and idle-without-request.
REQ-020 Load: mem_a = address+i for byte i (i=0..len-1) in cycle T+1+i, mem_wr=0; byte i sampled from mem_din in T+2+i; DONE in T+len+2.
REQ-021 Save: mem_a = address+i, mem_dout = sl_data[8i+7:8i], mem_wr=1 in cycle T+1+i; DONE in T+len+1; mem_wr=0 otherwise.
REQ-022 Address increment SHALL wrap modulo 2^32.
REQ-023 ld_data SHALL be little-endian assembly; for len 1/2, bits above SHALL be copies of the top loaded bit if signed, else 0; len 4 ignores signed.
REQ-024 ld_valid SHALL be 1 only in DONE of a load; ld_data holds its value until the next load completes.
REQ-025 sl_data_length not in {1,2,4}: no bus activity, go IDLE->DONE next cycle; load returns ld_data=0 with ld_valid=1.
REQ-026 Requests present in RD, WR or DONE SHALL be ignored; DONE always returns to IDLE next cycle.
REQ-027 Requests SHALL be held stable by upstream while stall_req=1; the block relies only on captured copies after T.

Reset
REQ-028 rst=1 at an edge SHALL force state IDLE, mem_a=0, mem_dout=0, mem_wr=0, ld_data=0, ld_valid=0, misalign=0, aborting any access in progress.
REQ-029 Aborted saves SHALL leave already-written bytes written; no further writes after the reset edge.

Configuration
REQ-030 Macro MEM_MISALIGN_TRAP_EN defined: len 2 with address[0]=1 or len 4 with address[1:0]!=0 SHALL perform no bus access, go DONE next cycle, pulse misalign in DONE, load ld_valid=1 with ld_data=0.
REQ-031 Macro MEM_MISALIGN_TRAP_EN undefined: misaligned accesses SHALL proceed byte-wise per REQ-020/021; misalign port absent.

Verification
REQ-032 RAM[0x100..0x103]=0x78,0x56,0x34,0x12; LW 0x100 at T -> mem_a 0x100..0x103 in T+1..T+4, ld_valid T+6, ld_data=0x12345678.
REQ-033 RAM[0x200]=0x80; LB 0x200 -> ld_data=0xFFFFFF80; LBU 0x200 -> 0x00000080, ld_valid at T+3.
REQ-034 SH 0x300 data 0xAABBCCDD -> mem_wr=1 with (0x300,0xDD) at T+1, (0x301,0xCC) at T+2, no third write, stall_req low at T+3.
REQ-035 SW 0xFFFFFFFE data 0x11223344 (macro off) -> writes at 0xFFFFFFFE,0xFFFFFFFF,0x0,0x1; macro on -> no writes, misalign pulse at T+1.
REQ-036 LW started, rst=1 at T+2 -> at T+3 state IDLE, mem_wr=0, ld_valid=0, stall_req follows load input only.

Source files
------------

// File: rtl/mem_access.sv
// mem_access: byte-serial load/store engine between the EX_MEM stage and an
// 8-bit synchronous RAM. A request accepted in IDLE is copied into local
// registers. The access then walks the bytes one per cycle, starting at the
// lowest address. Loads are assembled little-endian and sign- or
// zero-extended.
//
// Optional feature: define MEM_MISALIGN_TRAP_EN to trap misaligned halfword
// and word accesses. A trapped access makes no bus access and pulses
// misalign. Without the macro, misaligned accesses proceed byte-wise and the
// misalign port is absent.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   load, save          access requests (load wins if both are set)
//   sl_reg_address      byte address of the access
//   sl_data             store data, low bytes used
//   sl_data_length      access size in bytes (1, 2 or 4)
//   sl_data_signed      sign-extend enable for loads
//   mem_din             RAM read byte, one cycle after its address
//   mem_a/mem_dout      registered RAM address / write byte
//   mem_wr              registered RAM write strobe
//   stall_req           combinational pipeline hold request
//   ld_valid/ld_data    load completion pulse / held load result
//   misalign            misaligned-access pulse (MEM_MISALIGN_TRAP_EN only)
module mem_access (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        save,
  input  logic [31:0] sl_reg_address,
  input  logic [31:0] sl_data,
  input  logic [2:0]  sl_data_length,
  input  logic        sl_data_signed,
  input  logic [7:0]  mem_din,
  output logic [31:0] mem_a,
  output logic [7:0]  mem_dout,
  output logic        mem_wr,
  output logic        stall_req,
  output logic        ld_valid,
  output logic [31:0] ld_data
`ifdef MEM_MISALIGN_TRAP_EN
  ,
  output logic        misalign
`endif
);

  localparam int unsigned AW  = 32;
  localparam int unsigned DW  = 32;
  localparam int unsigned BW  = 8;
  localparam int unsigned LW  = 3;
  // Byte 0 of a store goes out directly from the request, so only the
  // upper bytes are kept.
  localparam int unsigned SDW = DW - BW;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    DONE = 2'd3
  } state_e;

  state_e         state_q, state_d;
  logic [AW-1:0]  addr_q, addr_d;
  logic [SDW-1:0] data_q, data_d;
  logic [LW-1:0]  len_q, len_d;
  logic           sgn_q, sgn_d;
  logic [LW-1:0]  cnt_q, cnt_d;
  logic [DW-1:0]  acc_q, acc_d;
  logic [AW-1:0]  mem_a_q, mem_a_d;
  logic [BW-1:0]  mem_dout_q, mem_dout_d;
  logic           mem_wr_q, mem_wr_d;
  logic [DW-1:0]  ld_data_q, ld_data_d;
  logic           ld_valid_q, ld_valid_d;
`ifdef MEM_MISALIGN_TRAP_EN
  logic           misalign_q, misalign_d;
`endif

  logic           req;
  logic           req_len_ok;
  logic           req_trap;
  logic [LW-1:0]  cnt_inc;
  logic [DW-1:0]  acc_nx;
  logic [BW-1:0]  st_byte;

  // Request qualification: legal sizes and, optionally, the alignment trap.
  always_comb begin
    req        = load | save;
    req_len_ok = (sl_data_length == LW'(1)) || (sl_data_length == LW'(2)) ||
                 (sl_data_length == LW'(4));
`ifdef MEM_MISALIGN_TRAP_EN
    req_trap   = ((sl_data_length == LW'(2)) && sl_reg_address[0]) ||
                 ((sl_data_length == LW'(4)) && (sl_reg_address[1:0] != 2'b00));
`else
    req_trap   = 1'b0;
`endif
  end

  // Per-byte helpers: next byte index, store byte select, load byte insert.
  always_comb begin
    cnt_inc = cnt_q + LW'(1);
    st_byte = '0;
    case (cnt_inc)
      LW'(1):  st_byte = data_q[7:0];
      LW'(2):  st_byte = data_q[15:8];
      LW'(3):  st_byte = data_q[23:16];
      default: st_byte = '0;
    endcase
    // Load byte k arrives while cnt_q == k+1.
    acc_nx = acc_q;
    case (cnt_q)
      LW'(1):  acc_nx[7:0]   = mem_din;
      LW'(2):  acc_nx[15:8]  = mem_din;
      LW'(3):  acc_nx[23:16] = mem_din;
      LW'(4):  acc_nx[31:24] = mem_din;
      default: acc_nx = acc_q;
    endcase
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    data_d     = data_q;
    len_d      = len_q;
    sgn_d      = sgn_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    mem_a_d    = mem_a_q;
    mem_dout_d = mem_dout_q;
    mem_wr_d   = 1'b0;
    ld_data_d  = ld_data_q;
    ld_valid_d = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
    misalign_d = 1'b0;
`endif
    stall_req  = 1'b0;

    case (state_q)
      IDLE: begin
        stall_req = req;
        if (req) begin
          addr_d = sl_reg_address;
          data_d = sl_data[DW-1:BW];
          len_d  = sl_data_length;
          sgn_d  = sl_data_signed;
          cnt_d  = '0;
          acc_d  = '0;
          if (!req_len_ok || req_trap) begin
            // No bus activity; a load still completes with zero data.
            state_d = DONE;
            if (load) begin
              ld_valid_d = 1'b1;
              ld_data_d  = '0;
            end
`ifdef MEM_MISALIGN_TRAP_EN
            misalign_d = req_trap;
`endif
          end else if (load) begin
            state_d = RD;
            mem_a_d = sl_reg_address;
          end else begin
            state_d    = WR;
            mem_a_d    = sl_reg_address;
            mem_dout_d = sl_data[BW-1:0];
            mem_wr_d   = 1'b1;
          end
        end
      end

      RD: begin
        stall_req = 1'b1;
        cnt_d     = cnt_inc;
        acc_d     = acc_nx;
        // Addresses run one cycle ahead of the returning bytes.
        if (cnt_inc < len_q) begin
          mem_a_d = addr_q + AW'(cnt_inc);
        end
        if (cnt_q == len_q) begin
          state_d    = DONE;
          ld_valid_d = 1'b1;
          case (len_q)
            LW'(1):  ld_data_d = {{24{sgn_q & acc_nx[7]}}, acc_nx[7:0]};
            LW'(2):  ld_data_d = {{16{sgn_q & acc_nx[15]}}, acc_nx[15:0]};
            default: ld_data_d = acc_nx;
          endcase
        end
      end

      WR: begin
        stall_req = 1'b1;
        if (cnt_inc < len_q) begin
          cnt_d      = cnt_inc;
          mem_a_d    = addr_q + AW'(cnt_inc);
          mem_dout_d = st_byte;
          mem_wr_d   = 1'b1;
        end else begin
          state_d = DONE;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      data_q     <= '0;
      len_q      <= '0;
      sgn_q      <= 1'b0;
      cnt_q      <= '0;
      acc_q      <= '0;
      mem_a_q    <= '0;
      mem_dout_q <= '0;
      mem_wr_q   <= 1'b0;
      ld_data_q  <= '0;
      ld_valid_q <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
      misalign_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      len_q      <= len_d;
      sgn_q      <= sgn_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      mem_a_q    <= mem_a_d;
      mem_dout_q <= mem_dout_d;
      mem_wr_q   <= mem_wr_d;
      ld_data_q  <= ld_data_d;
      ld_valid_q <= ld_valid_d;
`ifdef MEM_MISALIGN_TRAP_EN
      misalign_q <= misalign_d;
`endif
    end
  end

  assign mem_a    = mem_a_q;
  assign mem_dout = mem_dout_q;
  assign mem_wr   = mem_wr_q;
  assign ld_data  = ld_data_q;
  assign ld_valid = ld_valid_q;
`ifdef MEM_MISALIGN_TRAP_EN
  assign misalign = misalign_q;
`endif

endmodule

// File: tb/tb_mem_access.sv
// Directed testbench for mem_access with a 1 KiB synchronous byte RAM model.
module tb_mem_access;

  logic        clk;
  logic        rst;
  logic        load;
  logic        save;
  logic [31:0] sl_reg_address;
  logic [31:0] sl_data;
  logic [2:0]  sl_data_length;
  logic        sl_data_signed;
  logic [7:0]  mem_din;
  logic [31:0] mem_a;
  logic [7:0]  mem_dout;
  logic        mem_wr;
  logic        stall_req;
  logic        ld_valid;
  logic [31:0] ld_data;
`ifdef MEM_MISALIGN_TRAP_EN
  logic        misalign;
`endif

  int n_cmp;
  int n_err;
  int wr_cnt;
  int base;
  logic [7:0] ram [0:1023];

  mem_access dut (
    .clk            (clk),
    .rst            (rst),
    .load           (load),
    .save           (save),
    .sl_reg_address (sl_reg_address),
    .sl_data        (sl_data),
    .sl_data_length (sl_data_length),
    .sl_data_signed (sl_data_signed),
    .mem_din        (mem_din),
    .mem_a          (mem_a),
    .mem_dout       (mem_dout),
    .mem_wr         (mem_wr),
    .stall_req      (stall_req),
    .ld_valid       (ld_valid),
    .ld_data        (ld_data)
`ifdef MEM_MISALIGN_TRAP_EN
    ,
    .misalign       (misalign)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM: read data one cycle after the address, writes on the strobe.
  always @(posedge clk) begin
    mem_din <= ram[mem_a[9:0]];
    if (mem_wr) begin
      ram[mem_a[9:0]] <= mem_dout;
      wr_cnt          <= wr_cnt + 1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present a request in the current (IDLE) cycle T; it is dropped after T.
  task automatic issue(input logic ld, input logic sv, input logic [31:0] a,
                       input logic [31:0] d, input logic [2:0] len, input logic sg);
    load           = ld;
    save           = sv;
    sl_reg_address = a;
    sl_data        = d;
    sl_data_length = len;
    sl_data_signed = sg;
    #1;
    chk("stall_at_T", 32'(stall_req), 32'd1);
  endtask

  task automatic drop();
    load = 1'b0;
    save = 1'b0;
  endtask

  initial begin
    n_cmp  = 0;
    n_err  = 0;
    wr_cnt = 0;
    for (int i = 0; i < 1024; i++) ram[i] = 8'h00;
    ram[10'h100] = 8'h78; ram[10'h101] = 8'h56;
    ram[10'h102] = 8'h34; ram[10'h103] = 8'h12;
    ram[10'h200] = 8'h80; ram[10'h201] = 8'hF0;
    rst = 1'b1;
    load = 1'b0; save = 1'b0;
    sl_reg_address = '0; sl_data = '0; sl_data_length = '0; sl_data_signed = 1'b0;

    // Reset state
    step(); step();
    chk("rst_mem_a", mem_a, 32'h0);
    chk("rst_mem_dout", 32'(mem_dout), 32'h0);
    chk("rst_mem_wr", 32'(mem_wr), 32'h0);
    chk("rst_ld_valid", 32'(ld_valid), 32'h0);
    chk("rst_ld_data", ld_data, 32'h0);
    chk("rst_stall", 32'(stall_req), 32'h0);
    rst = 1'b0;
    step();

    // LW 0x100
    issue(1'b1, 1'b0, 32'h100, 32'h0, 3'd4, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(); drop();
      chk("lw_mem_a", mem_a, 32'h100 + 32'(i));
      chk("lw_mem_wr", 32'(mem_wr), 32'h0);
      chk("lw_stall", 32'(stall_req), 32'h1);
      chk("lw_ld_valid_early", 32'(ld_valid), 32'h0);
    end
    step();
    chk("lw_t5_ld_valid", 32'(ld_valid), 32'h0);
    chk("lw_t5_stall", 32'(stall_req), 32'h1);
    step();
    chk("lw_t6_ld_valid", 32'(ld_valid), 32'h1);
    chk("lw_t6_ld_data", ld_data, 32'h12345678);
    chk("lw_t6_stall", 32'(stall_req), 32'h0);
    step();
    chk("lw_t7_ld_valid", 32'(ld_valid), 32'h0);
    chk("lw_t7_ld_data_hold", ld_data, 32'h12345678);

    // LB / LBU 0x200
    issue(1'b1, 1'b0, 32'h200, 32'h0, 3'd1, 1'b1);
    step(); drop();
    chk("lb_mem_a", mem_a, 32'h200);
    step();
    chk("lb_t2_ld_valid", 32'(ld_valid), 32'h0);
    step();
    chk("lb_t3_ld_valid", 32'(ld_valid), 32'h1);
    chk("lb_ld_data", ld_data, 32'hFFFFFF80);
    step();
    issue(1'b1, 1'b0, 32'h200, 32'h0, 3'd1, 1'b0);
    step(); drop();
    step();
    chk("lbu_t2_ld_valid", 32'(ld_valid), 32'h0);
    step();
    chk("lbu_t3_ld_valid", 32'(ld_valid), 32'h1);
    chk("lbu_ld_data", ld_data, 32'h00000080);
    step();

    // LH signed 0x102 (positive) and load+save together on 0x200 (negative)
    issue(1'b1, 1'b0, 32'h102, 32'h0, 3'd2, 1'b1);
    step(); drop(); step(); step(); step();
    chk("lh_pos_ld_valid", 32'(ld_valid), 32'h1);
    chk("lh_pos_ld_data", ld_data, 32'h00001234);
    step();
    base = wr_cnt;
    issue(1'b1, 1'b1, 32'h200, 32'h99999999, 3'd2, 1'b1);
    step(); drop();
    chk("ldsv_mem_wr", 32'(mem_wr), 32'h0);
    chk("ldsv_mem_a", mem_a, 32'h200);
    step(); step(); step();
    chk("ldsv_ld_valid", 32'(ld_valid), 32'h1);
    chk("ldsv_ld_data", ld_data, 32'hFFFFF080);
    chk("ldsv_no_writes", 32'(wr_cnt - base), 32'd0);
    step();

    // SH 0x300
    base = wr_cnt;
    issue(1'b0, 1'b1, 32'h300, 32'hAABBCCDD, 3'd2, 1'b0);
    step(); drop();
    chk("sh_t1_wr", 32'(mem_wr), 32'h1);
    chk("sh_t1_a", mem_a, 32'h300);
    chk("sh_t1_dout", 32'(mem_dout), 32'hDD);
    step();
    chk("sh_t2_wr", 32'(mem_wr), 32'h1);
    chk("sh_t2_a", mem_a, 32'h301);
    chk("sh_t2_dout", 32'(mem_dout), 32'hCC);
    step();
    chk("sh_t3_wr", 32'(mem_wr), 32'h0);
    chk("sh_t3_stall", 32'(stall_req), 32'h0);
    chk("sh_t3_ld_valid", 32'(ld_valid), 32'h0);
    chk("sh_write_count", 32'(wr_cnt - base), 32'd2);
    step();

    // SW 0xFFFFFFFE (wraps), and misaligned LW 0x101
`ifdef MEM_MISALIGN_TRAP_EN
    base = wr_cnt;
    issue(1'b0, 1'b1, 32'hFFFFFFFE, 32'h11223344, 3'd4, 1'b0);
    step(); drop();
    chk("sw_trap_wr", 32'(mem_wr), 32'h0);
    chk("sw_trap_misalign", 32'(misalign), 32'h1);
    chk("sw_trap_stall", 32'(stall_req), 32'h0);
    step();
    chk("sw_trap_misalign_end", 32'(misalign), 32'h0);
    chk("sw_trap_no_writes", 32'(wr_cnt - base), 32'd0);
    issue(1'b1, 1'b0, 32'h101, 32'h0, 3'd4, 1'b0);
    step(); drop();
    chk("lw_trap_misalign", 32'(misalign), 32'h1);
    chk("lw_trap_ld_valid", 32'(ld_valid), 32'h1);
    chk("lw_trap_ld_data", ld_data, 32'h0);
    step();
`else
    issue(1'b0, 1'b1, 32'hFFFFFFFE, 32'h11223344, 3'd4, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(); drop();
      chk("sw_wrap_wr", 32'(mem_wr), 32'h1);
      chk("sw_wrap_a", mem_a, 32'hFFFFFFFE + 32'(i));
      chk("sw_wrap_dout", 32'(mem_dout), (32'h11223344 >> (8 * i)) & 32'hFF);
    end
    step();
    chk("sw_wrap_end_wr", 32'(mem_wr), 32'h0);
    chk("sw_wrap_end_stall", 32'(stall_req), 32'h0);
    step();
    issue(1'b1, 1'b0, 32'h101, 32'h0, 3'd4, 1'b0);
    step(); drop();
    chk("lw_mis_a", mem_a, 32'h101);
    step(); step(); step(); step(); step();
    chk("lw_mis_ld_valid", 32'(ld_valid), 32'h1);
    chk("lw_mis_ld_data", ld_data, 32'h00123456);
    step();
`endif

    // Illegal lengths: load len 3 completes with zero, save len 0 does nothing
    base = wr_cnt;
    issue(1'b1, 1'b0, 32'h100, 32'h0, 3'd3, 1'b0);
    step(); drop();
    chk("len3_ld_valid", 32'(ld_valid), 32'h1);
    chk("len3_ld_data", ld_data, 32'h0);
    chk("len3_stall", 32'(stall_req), 32'h0);
    chk("len3_wr", 32'(mem_wr), 32'h0);
    step();
    issue(1'b0, 1'b1, 32'h300, 32'h55555555, 3'd0, 1'b0);
    step(); drop();
    chk("len0_wr", 32'(mem_wr), 32'h0);
    chk("len0_ld_valid", 32'(ld_valid), 32'h0);
    chk("len0_stall", 32'(stall_req), 32'h0);
    step();
    chk("badlen_no_writes", 32'(wr_cnt - base), 32'd0);

    // Reset during a load
    issue(1'b1, 1'b0, 32'h100, 32'h0, 3'd4, 1'b0);
    step(); drop();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_ld_wr", 32'(mem_wr), 32'h0);
    chk("abort_ld_valid", 32'(ld_valid), 32'h0);
    chk("abort_ld_data", ld_data, 32'h0);
    chk("abort_ld_mem_a", mem_a, 32'h0);
    chk("abort_ld_stall_idle", 32'(stall_req), 32'h0);
    load = 1'b1;
    #1;
    chk("abort_ld_stall_req", 32'(stall_req), 32'h1);
    load = 1'b0;
    #1;
    chk("abort_ld_stall_drop", 32'(stall_req), 32'h0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("abort_ld_no_valid", 32'(ld_valid), 32'h0);
    end

    // Reset during a save: bytes already written remain, nothing after
    base = wr_cnt;
    issue(1'b0, 1'b1, 32'h380, 32'hDEADBEEF, 3'd4, 1'b0);
    step(); drop();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_sv_wr", 32'(mem_wr), 32'h0);
    step(); step(); step();
    chk("abort_sv_count", 32'(wr_cnt - base), 32'd2);
    chk("abort_sv_b0", 32'(ram[10'h380]), 32'hEF);
    chk("abort_sv_b1", 32'(ram[10'h381]), 32'hBE);
    chk("abort_sv_b2", 32'(ram[10'h382]), 32'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
